// File: rtl/uart_rx_axis.sv
// ----------------------------------------------------------------------------
// uart_rx_axis
//
// UART receiver feeding an AXI-Stream master. The asynchronous serial line is
// brought into the clk domain through a two-flop synchronizer. A four-state
// FSM then locates the middle of the start bit and samples each data bit and
// the stop bit at bit-period intervals. Each good byte goes into a small
// FIFO, and the FIFO head is presented as an AXI-Stream beat.
//
// Ports
//   clk          in   system clock, rising edge
//   rst_n        in   asynchronous active-low reset
//   uart_rx      in   serial line, idle high, asynchronous to clk
//   m_axis_data  out  received byte (LSB = first bit on the wire)
//   m_axis_valid out  FIFO head holds a byte
//   m_axis_ready in   consumer accepts the beat
//   frame_err    out  1-cycle pulse: stop bit sampled low, byte discarded
//   overrun      out  1-cycle pulse: good byte dropped, FIFO full
// ----------------------------------------------------------------------------
module uart_rx_axis #(
    parameter int DATA_BITS    = 8,
    parameter int CLKS_PER_BIT = 87,
    parameter int FIFO_DEPTH   = 4
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 uart_rx,
    output logic [DATA_BITS-1:0] m_axis_data,
    output logic                 m_axis_valid,
    input  logic                 m_axis_ready,
    output logic                 frame_err,
    output logic                 overrun
);

    localparam int CNT_W = $clog2(CLKS_PER_BIT);
    localparam int IDX_W = (DATA_BITS > 1) ? $clog2(DATA_BITS) : 1;
    localparam int AW    = $clog2(FIFO_DEPTH);
    localparam int PTR_W = AW + 1;

    // Half a bit period: the start bit is checked near its middle. From then
    // on, sampling every full period lands near the middle of each later bit.
    localparam logic [CNT_W-1:0] HALF     = CNT_W'((CLKS_PER_BIT - 1) / 2);
    localparam logic [CNT_W-1:0] LAST     = CNT_W'(CLKS_PER_BIT - 1);
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(DATA_BITS - 1);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        START = 2'd1,
        DATA  = 2'd2,
        STOP  = 2'd3
    } state_t;

    // ------------------------------------------------------------------
    // State
    // ------------------------------------------------------------------
    logic                 rx_meta_q;
    logic                 rx_s_q;

    state_t               state_q,  state_d;
    logic [CNT_W-1:0]     cnt_q,    cnt_d;
    logic [IDX_W-1:0]     idx_q,    idx_d;
    logic [DATA_BITS-1:0] shift_q,  shift_d;

    logic [PTR_W-1:0]     wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0]     rd_ptr_q, rd_ptr_d;
    logic [DATA_BITS-1:0] mem_q [FIFO_DEPTH];
    logic [DATA_BITS-1:0] mem_d [FIFO_DEPTH];

    logic                 frame_err_q, frame_err_d;
    logic                 overrun_q,   overrun_d;

    // Internal strobes from the FSM to the FIFO logic.
    logic                 push_req;
    logic                 frame_bad;

    logic                 fifo_empty;
    logic                 fifo_full;
    logic                 pop;
    logic                 push;

    // ------------------------------------------------------------------
    // Input synchronizer. It resets to the idle-high line level, so a reset
    // release never looks like a start bit.
    // ------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rx_meta_q <= 1'b1;
            rx_s_q    <= 1'b1;
        end else begin
            rx_meta_q <= uart_rx;
            rx_s_q    <= rx_meta_q;
        end
    end

    // ------------------------------------------------------------------
    // Receive FSM: next-state and datapath
    // ------------------------------------------------------------------
    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        idx_d     = idx_q;
        shift_d   = shift_q;
        push_req  = 1'b0;
        frame_bad = 1'b0;

        case (state_q)
            IDLE: begin
                if (!rx_s_q) begin
                    state_d = START;
                    cnt_d   = '0;
                end
            end

            START: begin
                if (cnt_q == HALF) begin
                    cnt_d = '0;
                    if (!rx_s_q) begin
                        state_d = DATA;
                        idx_d   = '0;
                    end else begin
                        // Line went high again before mid start bit:
                        // treat it as noise and wait for a real edge.
                        state_d = IDLE;
                    end
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end

            DATA: begin
                if (cnt_q == LAST) begin
                    cnt_d   = '0;
                    // LSB-first on the wire: shift in from the top, so the
                    // first bit ends up at bit 0.
                    shift_d = {rx_s_q, shift_q[DATA_BITS-1:1]};
                    if (idx_q == LAST_IDX) begin
                        state_d = STOP;
                        idx_d   = '0;
                    end else begin
                        idx_d = idx_q + IDX_W'(1);
                    end
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end

            STOP: begin
                if (cnt_q == LAST) begin
                    // Return to IDLE at mid stop bit. A start bit that
                    // follows with no gap is still caught.
                    cnt_d   = '0;
                    state_d = IDLE;
                    if (rx_s_q) begin
                        push_req = 1'b1;
                    end else begin
                        frame_bad = 1'b1;
                    end
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end

            default: begin
                state_d = IDLE;
                cnt_d   = '0;
                idx_d   = '0;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            idx_q   <= '0;
            shift_q <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            idx_q   <= idx_d;
            shift_q <= shift_d;
        end
    end

    // ------------------------------------------------------------------
    // Byte FIFO. Each pointer has one extra wrap bit. Equal pointers mean
    // empty. Pointers that differ only in the wrap bit mean full.
    // ------------------------------------------------------------------
    always_comb begin
        fifo_empty = (wr_ptr_q == rd_ptr_q);
        fifo_full  = (wr_ptr_q[AW] != rd_ptr_q[AW]) &&
                     (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);

        pop  = !fifo_empty && m_axis_ready;
        // A pop in the same cycle frees the head slot. A full FIFO can
        // therefore still take the new byte.
        push = push_req && (!fifo_full || pop);

        wr_ptr_d = wr_ptr_q + PTR_W'(push);
        rd_ptr_d = rd_ptr_q + PTR_W'(pop);

        mem_d = mem_q;
        if (push) begin
            mem_d[wr_ptr_q[AW-1:0]] = shift_q;
        end

        frame_err_d = frame_bad;
        overrun_d   = push_req && fifo_full && !pop;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_q    <= '0;
            rd_ptr_q    <= '0;
            frame_err_q <= 1'b0;
            overrun_q   <= 1'b0;
            for (int i = 0; i < FIFO_DEPTH; i++) begin
                mem_q[i] <= '0;
            end
        end else begin
            wr_ptr_q    <= wr_ptr_d;
            rd_ptr_q    <= rd_ptr_d;
            frame_err_q <= frame_err_d;
            overrun_q   <= overrun_d;
            mem_q       <= mem_d;
        end
    end

    // ------------------------------------------------------------------
    // Stream port. All outputs come straight from flops. Valid does not
    // depend on ready.
    // ------------------------------------------------------------------
    assign m_axis_valid = !fifo_empty;
    assign m_axis_data  = mem_q[rd_ptr_q[AW-1:0]];
    assign frame_err    = frame_err_q;
    assign overrun      = overrun_q;

endmodule

// File: tb/tb_uart_rx_axis.sv
// ----------------------------------------------------------------------------
// tb_uart_rx_axis
//
// Directed bench for uart_rx_axis with CLKS_PER_BIT=16, FIFO_DEPTH=4 and
// DATA_BITS=8. Serial frames are driven one cycle-accurate bit at a time. A
// monitor collects accepted beats, counts the flag cycles and watches
// stream stability. The main sequence compares all of that against
// hand-computed values.
// ----------------------------------------------------------------------------
`timescale 1ns/1ps

module tb_uart_rx_axis;

    localparam int CPB   = 16;
    localparam int DEPTH = 4;
    localparam int DB    = 8;

    logic          clk = 1'b0;
    logic          rst_n;
    logic          uart_rx;
    logic [DB-1:0] m_axis_data;
    logic          m_axis_valid;
    logic          m_axis_ready;
    logic          frame_err;
    logic          overrun;

    int n_assert = 0;
    int n_fail   = 0;

    always #5 clk = ~clk;

    uart_rx_axis #(
        .DATA_BITS    (DB),
        .CLKS_PER_BIT (CPB),
        .FIFO_DEPTH   (DEPTH)
    ) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .uart_rx      (uart_rx),
        .m_axis_data  (m_axis_data),
        .m_axis_valid (m_axis_valid),
        .m_axis_ready (m_axis_ready),
        .frame_err    (frame_err),
        .overrun      (overrun)
    );

    // ---------------- monitor ----------------
    logic [DB-1:0] beats[$];
    int            fe_hi     = 0;
    int            ov_hi     = 0;
    int            stab_viol = 0;
    logic          pv = 1'b0;
    logic          pr = 1'b0;
    logic [DB-1:0] pd = '0;

    always @(negedge clk) begin
        if (!rst_n) begin
            pv = 1'b0;
            pr = 1'b0;
        end else begin
            if (pv && !pr && (m_axis_valid !== 1'b1 || m_axis_data !== pd))
                stab_viol++;
            if (m_axis_valid === 1'b1 && m_axis_ready === 1'b1)
                beats.push_back(m_axis_data);
            if (frame_err === 1'b1) fe_hi++;
            if (overrun === 1'b1)   ov_hi++;
            pv = m_axis_valid;
            pr = m_axis_ready;
            pd = m_axis_data;
        end
    end

    initial begin
        #2_000_000;
        $display("FAIL timeout: observed no end of test, expected end within 2 ms");
        $fatal(1, "timeout");
    end

    // ---------------- helpers ----------------
    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    function automatic logic [31:0] beat_at(input int i);
        if (i < beats.size()) return {24'd0, beats[i]};
        return 32'hdead_beef;
    endfunction

    task automatic clear_mon();
        beats.delete();
        fe_hi = 0;
        ov_hi = 0;
    endtask

    task automatic cycles(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    // Must be entered at posedge+1. It returns at posedge+1, so calls can be
    // chained back to back with no idle gap.
    task automatic send_byte(input logic [7:0] b, input logic stop_bit);
        uart_rx = 1'b0;
        cycles(CPB);
        for (int i = 0; i < DB; i++) begin
            uart_rx = b[i];
            cycles(CPB);
        end
        uart_rx = stop_bit;
        cycles(CPB);
        uart_rx = 1'b1;
    endtask

    // ---------------- sequence ----------------
    int   lat;
    logic found;
    logic tx_done;

    initial begin
        rst_n        = 1'b0;
        uart_rx      = 1'b1;
        m_axis_ready = 1'b0;
        tx_done      = 1'b0;
        repeat (2) @(posedge clk);
        #1;

        // Reset state
        check("rst_valid",     32'(m_axis_valid), 32'd0);
        check("rst_data",      32'(m_axis_data),  32'd0);
        check("rst_frame_err", 32'(frame_err),    32'd0);
        check("rst_overrun",   32'(overrun),      32'd0);
        rst_n = 1'b1;
        cycles(4);

        // Single byte 0xA5 with latency window
        clear_mon();
        m_axis_ready = 1'b1;
        lat   = 0;
        found = 1'b0;
        fork
            send_byte(8'hA5, 1'b1);
            begin
                while (!found && lat < 400) begin
                    @(posedge clk);
                    lat++;
                    @(negedge clk);
                    if (m_axis_valid === 1'b1) found = 1'b1;
                end
            end
        join
        cycles(20);
        check("a5_valid_seen",  32'(found), 32'd1);
        check("a5_latency_win", 32'(lat >= 153 && lat <= 155), 32'd1);
        check("a5_beats",       beats.size(), 32'd1);
        check("a5_data",        beat_at(0), 32'hA5);
        check("a5_frame_err",   fe_hi, 32'd0);
        check("a5_overrun",     ov_hi, 32'd0);

        // Overrun: five bytes back to back with ready low
        clear_mon();
        m_axis_ready = 1'b0;
        for (int i = 1; i <= 4; i++) send_byte(8'(i), 1'b1);
        check("ovr_none_at_4",   ov_hi, 32'd0);
        check("ovr_valid_full",  32'(m_axis_valid), 32'd1);
        send_byte(8'h05, 1'b1);
        cycles(5);
        check("ovr_pulse_once",  ov_hi, 32'd1);
        check("ovr_no_beats",    beats.size(), 32'd0);
        m_axis_ready = 1'b1;
        cycles(10);
        check("ovr_beats",       beats.size(), 32'd4);
        for (int i = 0; i < 4; i++) check("ovr_order", beat_at(i), 32'(i + 1));
        check("ovr_drained",     32'(m_axis_valid), 32'd0);

        // Framing error followed by a good byte
        clear_mon();
        send_byte(8'h3C, 1'b0);
        cycles(2 * CPB);
        check("fe_pulse_1cyc",   fe_hi, 32'd1);
        check("fe_no_beat",      beats.size(), 32'd0);
        check("fe_no_overrun",   ov_hi, 32'd0);
        send_byte(8'h55, 1'b1);
        cycles(20);
        check("fe_next_beats",   beats.size(), 32'd1);
        check("fe_next_data",    beat_at(0), 32'h55);
        check("fe_no_new_err",   fe_hi, 32'd1);

        // Glitch of four cycles on an idle line
        clear_mon();
        uart_rx = 1'b0;
        cycles(4);
        uart_rx = 1'b1;
        cycles(40);
        check("gl_no_beat",      beats.size(), 32'd0);
        check("gl_no_fe",        fe_hi, 32'd0);
        check("gl_no_ov",        ov_hi, 32'd0);
        send_byte(8'hC3, 1'b1);
        cycles(20);
        check("gl_next_beats",   beats.size(), 32'd1);
        check("gl_next_data",    beat_at(0), 32'hC3);

        // Backpressure with random ready
        clear_mon();
        stab_viol = 0;
        m_axis_ready = 1'b0;
        tx_done = 1'b0;
        fork
            begin
                send_byte(8'h11, 1'b1);
                send_byte(8'h22, 1'b1);
                send_byte(8'h33, 1'b1);
                tx_done = 1'b1;
            end
            begin
                while (!tx_done) begin
                    @(posedge clk);
                    #1;
                    m_axis_ready = 1'($urandom_range(0, 1));
                end
            end
        join
        m_axis_ready = 1'b1;
        cycles(20);
        check("bp_beats",        beats.size(), 32'd3);
        check("bp_data0",        beat_at(0), 32'h11);
        check("bp_data1",        beat_at(1), 32'h22);
        check("bp_data2",        beat_at(2), 32'h33);
        check("bp_stable",       stab_viol, 32'd0);

        // Reset during the data bits of 0x7E, with a byte already buffered
        clear_mon();
        m_axis_ready = 1'b0;
        send_byte(8'h7E, 1'b1);
        cycles(4);
        check("rm_pre_valid",    32'(m_axis_valid), 32'd1);
        check("rm_pre_data",     32'(m_axis_data),  32'h7E);
        uart_rx = 1'b0;
        cycles(CPB);
        uart_rx = 1'b0;
        cycles(CPB);
        uart_rx = 1'b1;
        cycles(CPB / 2);
        #2;
        rst_n = 1'b0;
        #1;
        check("rm_valid",        32'(m_axis_valid), 32'd0);
        check("rm_data",         32'(m_axis_data),  32'd0);
        check("rm_frame_err",    32'(frame_err),    32'd0);
        check("rm_overrun",      32'(overrun),      32'd0);
        uart_rx = 1'b1;
        cycles(3);
        rst_n = 1'b1;
        cycles(2 * CPB);
        clear_mon();
        m_axis_ready = 1'b1;
        send_byte(8'h81, 1'b1);
        cycles(20);
        check("rm_next_beats",   beats.size(), 32'd1);
        check("rm_next_data",    beat_at(0), 32'h81);
        check("rm_next_fe",      fe_hi, 32'd0);
        check("rm_next_ov",      ov_hi, 32'd0);
        check("rm_final_empty",  32'(m_axis_valid), 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule

// File: doc/uart_rx_axis.md
Name: uart_rx_axis

Overview:
- UART receiver feeding an AXI-Stream master; the inbound counterpart of the AXI-Stream-to-UART transmit path.
- Samples an asynchronous serial line (8N1 by default), re-times each byte and buffers it in a small FIFO.
- Presents each byte as an AXI-Stream beat toward the downstream consumer.
- Sits beside the TX path in the top-level wrapper: rx pin in, stream out.

Parameters:
- DATA_BITS, 8, data bits per UART frame and width of m_axis_data.
- CLKS_PER_BIT, 87, clk cycles per bit period; must be >= 4.
- FIFO_DEPTH, 4, byte entries buffered between receiver and stream port; power of two, >= 2.

Ports:
- clk  input  1  system clock; all logic on rising edge.
- rst_n  input  1  asynchronous active-low reset.
- uart_rx  input  1  serial line, idle high, asynchronous to clk.
- m_axis_data  output  DATA_BITS  received byte; LSB is the first bit on the wire.
- m_axis_valid  output  1  FIFO head holds a byte.
- m_axis_ready  input  1  consumer accepts the beat.
- frame_err  output  1  one-cycle pulse: stop bit sampled low, byte discarded.
- overrun  output  1  one-cycle pulse: good byte dropped because the FIFO was full.

Behaviour:
- Reset (async assert, sync release):
  - Synchronizer flops = 1.
  - FSM = IDLE; counters, shift register, FIFO pointers = 0.
  - m_axis_valid = 0, m_axis_data = 0, frame_err = 0, overrun = 0.
  - Reset mid-frame abandons the partial byte and flushes the FIFO.
- uart_rx passes through a 2-flop synchronizer (rx_s); the FSM uses only rx_s.
- Let H = (CLKS_PER_BIT-1)/2 (integer division).
- FSM states IDLE, START, DATA, STOP; a bit counter cnt runs 0..CLKS_PER_BIT-1.
- IDLE:
  - rx_s == 0 -> START, cnt = 0.
- START:
  - At cnt == H, sample rx_s.
  - Sample 0 -> DATA, cnt = 0, bit index = 0.
  - Sample 1 -> IDLE (glitch rejected, no flags).
- DATA:
  - At cnt == CLKS_PER_BIT-1, sample rx_s into shift register LSB-first and reset cnt.
  - After the DATA_BITS-th sample -> STOP.
- STOP:
  - At cnt == CLKS_PER_BIT-1 (centre of stop bit), sample rx_s, then -> IDLE in the same cycle.
  - This permits back-to-back frames with no idle gap.
- Stop sample == 1:
  - Push the byte to the FIFO.
  - If FIFO full and no pop this cycle: drop the byte and pulse overrun for 1 cycle.
- Stop sample == 0:
  - Pulse frame_err for 1 cycle, discard the byte, no push.
- Latency:
  - Stop sample occurs 2 + H + (DATA_BITS+1)*CLKS_PER_BIT cycles after the uart_rx falling edge (bench tolerance ±1).
  - m_axis_valid rises the cycle after the push (FIFO write is registered).
- AXI-Stream handshake:
  - m_axis_valid = FIFO not empty; m_axis_data = FIFO head.
  - Pop on m_axis_valid && m_axis_ready.
  - While valid && !ready, data and valid are held stable.
  - Valid never drops without a handshake, except on reset.
  - Valid does not depend combinationally on ready.
- Simultaneous push and pop:
  - Both occur; occupancy unchanged.
  - Applies even when full: no overrun.
  - When empty, the pushed byte appears next cycle.
- Pointers wrap modulo FIFO_DEPTH; an extra occupancy bit distinguishes full from empty.

Test Plan:
- Common setup: CLKS_PER_BIT=16, FIFO_DEPTH=4, DATA_BITS=8.
- Single byte: send 0xA5 (8N1), m_axis_ready=1 -> exactly one beat with m_axis_data=0xA5; valid rises within 2+7+144+1 ±1 cycles of the start edge; frame_err=0, overrun=0.
- Overrun: m_axis_ready=0, send 0x01..0x05 back-to-back -> overrun pulses once, at the 5th stop sample. Then ready=1 -> beats 0x01,0x02,0x03,0x04 in order, then valid=0.
- Framing error: send 0x3C with stop bit driven 0 -> frame_err 1-cycle pulse, no beat. A following 0x55 with a correct stop bit -> one beat 0x55.
- Glitch: hold uart_rx low for 4 cycles, then high -> FSM returns to IDLE, no beat, no flags. A following 0xC3 is received correctly.
- Backpressure: send 0x11,0x22,0x33 while ready toggles randomly -> three beats in order. Data and valid stay stable across every valid && !ready cycle.
- Reset mid-frame: assert rst_n low during the DATA bits of 0x7E -> all outputs 0 immediately (async). After release, send 0x81 -> a single beat 0x81, no flags.
